// File: rtl/cam_pkg.sv
// Shared CAM definitions: default geometry plus the command, response and
// controller state encodings used by both the writer and the lookup CAM.
package cam_pkg;

   localparam int CAM_DEPTH = 8;
   localparam int CAM_WIDTH = 16;

   typedef enum logic [1:0] {
      OP_NOP    = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_CLEAR  = 2'd3
   } cam_op_e;

   typedef enum logic [1:0] {
      STAT_OK   = 2'd0,
      STAT_DUP  = 2'd1,
      STAT_FULL = 2'd2,
      STAT_MISS = 2'd3
   } cam_status_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CLR  = 2'd2,
      RESP = 2'd3
   } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: reports the smallest set bit position of vec
// and whether any bit was set at all.
module cam_prio_enc #(
   parameter int N  = 8,
   parameter int AW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [AW-1:0] idx,
   output logic          found
);

   // Scanning from the top down lets the lowest set bit overwrite the others.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = AW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_writer.sv
// Write-side CAM controller: owns entry storage and valid bits, and executes
// insert/delete/clear commands one at a time with a single response each.
module cam_writer
   import cam_pkg::*;
#(
   parameter int DEPTH = CAM_DEPTH,
   parameter int WIDTH = CAM_WIDTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [WIDTH-1:0]       cmd_data,
   output logic                   rsp_valid,
   output logic [1:0]             rsp_status,
   output logic [AW-1:0]          rsp_addr,
   output logic [DEPTH*WIDTH-1:0] entry_data,
   output logic [DEPTH-1:0]       entry_valid,
   output logic [AW:0]            count,
   output logic                   full,
   output logic                   empty
);

   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

   cam_state_e       state;
   cam_op_e          op_q;
   logic [WIDTH-1:0] key_q;
   logic [AW-1:0]    sweep_idx;
   logic [WIDTH-1:0] entries [DEPTH];

   logic [DEPTH-1:0] match_vec;
   logic [AW-1:0]    hit_idx;
   logic             hit_found;
   logic [AW-1:0]    free_idx;
   logic             free_found;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flatten
      assign entry_data[g*WIDTH +: WIDTH] = entries[g];
   end

   // Stale data behind a cleared valid bit must never produce a hit.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = entry_valid[i] && (entries[i] == key_q);
      end
   end

   cam_prio_enc #(.N(DEPTH), .AW(AW)) u_hit_enc (
      .vec   (match_vec),
      .idx   (hit_idx),
      .found (hit_found)
   );

   cam_prio_enc #(.N(DEPTH), .AW(AW)) u_free_enc (
      .vec   (~entry_valid),
      .idx   (free_idx),
      .found (free_found)
   );

   assign cmd_ready = (state == IDLE);
   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= OP_NOP;
         key_q       <= '0;
         sweep_idx   <= '0;
         rsp_valid   <= 1'b0;
         rsp_status  <= STAT_OK;
         rsp_addr    <= '0;
         entry_valid <= '0;
         count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cam_op_e'(cmd_op);
                  key_q     <= cmd_data;
                  sweep_idx <= '0;
                  state     <= (cam_op_e'(cmd_op) == OP_CLEAR) ? CLR : EXEC;
               end
            end
            EXEC: begin
               state      <= RESP;
               rsp_valid  <= 1'b1;
               rsp_status <= STAT_OK;
               rsp_addr   <= '0;
               case (op_q)
                  OP_INSERT: begin
                     if (hit_found) begin
                        rsp_status <= STAT_DUP;
                        rsp_addr   <= hit_idx;
                     end else if (!free_found) begin
                        rsp_status <= STAT_FULL;
                     end else begin
                        entries[free_idx]     <= key_q;
                        entry_valid[free_idx] <= 1'b1;
                        count                 <= count + (AW+1)'(1);
                        rsp_addr              <= free_idx;
                     end
                  end
                  OP_DELETE: begin
                     if (hit_found) begin
                        entry_valid[hit_idx] <= 1'b0;
                        count                <= count - (AW+1)'(1);
                        rsp_addr             <= hit_idx;
                     end else begin
                        rsp_status <= STAT_MISS;
                     end
                  end
                  default: ;
               endcase
            end
            // One entry per cycle; count is only dropped once the sweep completes.
            CLR: begin
               entry_valid[sweep_idx] <= 1'b0;
               entries[sweep_idx]     <= '0;
               if (sweep_idx == LAST_IDX) begin
                  count      <= '0;
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= STAT_OK;
                  rsp_addr   <= '0;
               end else begin
                  sweep_idx <= sweep_idx + AW'(1);
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_writer.sv
// Directed self-checking bench for cam_writer: a vector table for single
// commands plus hand-written CLEAR and reset-abort sequences.
module tb_cam_writer;
   import cam_pkg::*;

   localparam int DEPTH = 8;
   localparam int WIDTH = 16;
   localparam int AW    = 3;

   logic                   clk;
   logic                   rst_n;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic [WIDTH-1:0]       cmd_data;
   logic                   rsp_valid;
   logic [1:0]             rsp_status;
   logic [AW-1:0]          rsp_addr;
   logic [DEPTH*WIDTH-1:0] entry_data;
   logic [DEPTH-1:0]       entry_valid;
   logic [AW:0]            count;
   logic                   full;
   logic                   empty;

   cam_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .rsp_valid   (rsp_valid),
      .rsp_status  (rsp_status),
      .rsp_addr    (rsp_addr),
      .entry_data  (entry_data),
      .entry_valid (entry_valid),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]       op;
      logic [WIDTH-1:0] data;
      logic [1:0]       status;
      logic [AW-1:0]    addr;
      logic [AW:0]      cnt;
      logic [DEPTH-1:0] valid;
      logic             is_full;
   } vec_t;

   vec_t vecs [17];
   int   checks   = 0;
   int   failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Handshake one command and return the number of negedges until rsp_valid.
   task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                output int latency);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      latency   = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            latency = k;
            break;
         end
      end
      if (latency == 0) checkOutput("rsp_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  lat;
      bit  seen;

      vecs[0]  = '{2'd1, 16'h0000, 2'd0, 3'd0, 4'd1, 8'h01, 1'b0};
      vecs[1]  = '{2'd1, 16'h0001, 2'd0, 3'd1, 4'd2, 8'h03, 1'b0};
      vecs[2]  = '{2'd1, 16'h0002, 2'd0, 3'd2, 4'd3, 8'h07, 1'b0};
      vecs[3]  = '{2'd1, 16'h0002, 2'd1, 3'd2, 4'd3, 8'h07, 1'b0};
      vecs[4]  = '{2'd2, 16'h0009, 2'd3, 3'd0, 4'd3, 8'h07, 1'b0};
      vecs[5]  = '{2'd2, 16'h0001, 2'd0, 3'd1, 4'd2, 8'h05, 1'b0};
      vecs[6]  = '{2'd1, 16'h0007, 2'd0, 3'd1, 4'd3, 8'h07, 1'b0};
      vecs[7]  = '{2'd1, 16'h0003, 2'd0, 3'd3, 4'd4, 8'h0F, 1'b0};
      vecs[8]  = '{2'd1, 16'h0004, 2'd0, 3'd4, 4'd5, 8'h1F, 1'b0};
      vecs[9]  = '{2'd1, 16'h0005, 2'd0, 3'd5, 4'd6, 8'h3F, 1'b0};
      vecs[10] = '{2'd1, 16'h0006, 2'd0, 3'd6, 4'd7, 8'h7F, 1'b0};
      vecs[11] = '{2'd1, 16'h0008, 2'd0, 3'd7, 4'd8, 8'hFF, 1'b1};
      vecs[12] = '{2'd0, 16'h0003, 2'd0, 3'd0, 4'd8, 8'hFF, 1'b1};
      vecs[13] = '{2'd1, 16'h00AA, 2'd2, 3'd0, 4'd8, 8'hFF, 1'b1};
      vecs[14] = '{2'd2, 16'h0004, 2'd0, 3'd4, 4'd7, 8'hEF, 1'b0};
      vecs[15] = '{2'd2, 16'h0004, 2'd3, 3'd0, 4'd7, 8'hEF, 1'b0};
      vecs[16] = '{2'd1, 16'h0004, 2'd0, 3'd4, 4'd8, 8'hFF, 1'b1};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_data  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_cmd_ready", cmd_ready, 1);
      checkOutput("reset_empty", empty, 1);
      checkOutput("reset_full", full, 0);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_status", rsp_status, 0);
      checkOutput("reset_rsp_addr", rsp_addr, 0);
      checkOutput("reset_entry_valid", entry_valid, 0);
      checkOutput("reset_entry_data_zero", entry_data == '0, 1);

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].op, vecs[i].data, lat);
         checkOutput($sformatf("v%0d_latency", i), lat, 2);
         checkOutput($sformatf("v%0d_status", i), rsp_status, vecs[i].status);
         checkOutput($sformatf("v%0d_addr", i), rsp_addr, vecs[i].addr);
         checkOutput($sformatf("v%0d_count", i), count, vecs[i].cnt);
         checkOutput($sformatf("v%0d_entry_valid", i), entry_valid, vecs[i].valid);
         checkOutput($sformatf("v%0d_full", i), full, vecs[i].is_full);
         checkOutput($sformatf("v%0d_empty", i), empty, 0);
         if (vecs[i].op == 2'd1 && vecs[i].status == 2'd0)
            checkOutput($sformatf("v%0d_entry_data", i),
                        entry_data[vecs[i].addr*WIDTH +: WIDTH], vecs[i].data);
         @(negedge clk);
         checkOutput($sformatf("v%0d_rsp_pulse_end", i), rsp_valid, 0);
         checkOutput($sformatf("v%0d_ready_back", i), cmd_ready, 1);
      end

      // CLEAR from full while cmd_valid stays asserted with an INSERT behind it.
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_data  = 16'h0000;
      @(posedge clk);
      #1;
      cmd_op   = 2'd1;
      cmd_data = 16'h00BB;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         checkOutput($sformatf("clr_ready_low_%0d", k), cmd_ready, 0);
         checkOutput($sformatf("clr_rsp_valid_%0d", k), rsp_valid, (k == 9) ? 1 : 0);
      end
      checkOutput("clr_status", rsp_status, 0);
      checkOutput("clr_addr", rsp_addr, 0);
      checkOutput("clr_count", count, 0);
      checkOutput("clr_empty", empty, 1);
      checkOutput("clr_entry_valid", entry_valid, 0);
      checkOutput("clr_entry_data_zero", entry_data == '0, 1);
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      @(negedge clk);
      checkOutput("clr_ready_back", cmd_ready, 1);
      checkOutput("clr_rsp_pulse_end", rsp_valid, 0);
      checkOutput("clr_held_insert_ignored", count, 0);

      applyStimulus(2'd1, 16'h0011, lat);
      applyStimulus(2'd1, 16'h0022, lat);
      applyStimulus(2'd1, 16'h0033, lat);
      applyStimulus(2'd1, 16'h0044, lat);
      applyStimulus(2'd1, 16'h0055, lat);
      checkOutput("pre_abort_valid", entry_valid, 8'h1F);

      // Start a CLEAR and pull reset while the sweep sits at index 3.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      repeat (4) @(negedge clk);
      checkOutput("abort_sweep_progress", entry_valid, 8'h18);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_entry_valid", entry_valid, 0);
      checkOutput("abort_count", count, 0);
      checkOutput("abort_ready", cmd_ready, 1);
      checkOutput("abort_empty", empty, 1);
      checkOutput("abort_entry_data_zero", entry_data == '0, 1);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      checkOutput("abort_no_response", seen, 0);

      applyStimulus(2'd1, 16'h0005, lat);
      checkOutput("post_abort_latency", lat, 2);
      checkOutput("post_abort_status", rsp_status, 0);
      checkOutput("post_abort_addr", rsp_addr, 0);
      checkOutput("post_abort_count", count, 1);
      checkOutput("post_abort_data", entry_data[WIDTH-1:0], 16'h0005);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
